// File: rtl/keypad_pkg.sv
// Shared key encodings, column FSM state type and the column/row to key lookup
// for the 4x4 Pmod keypad scanner.
package keypad_pkg;

  // Key codes are {none, hex}; the top bit marks "no single key pressed".
  localparam logic [4:0] KEY_NONE = 5'b1_0000;
  localparam logic [4:0] KEY_0    = 5'h00;
  localparam logic [4:0] KEY_1    = 5'h01;
  localparam logic [4:0] KEY_2    = 5'h02;
  localparam logic [4:0] KEY_3    = 5'h03;
  localparam logic [4:0] KEY_4    = 5'h04;
  localparam logic [4:0] KEY_5    = 5'h05;
  localparam logic [4:0] KEY_6    = 5'h06;
  localparam logic [4:0] KEY_7    = 5'h07;
  localparam logic [4:0] KEY_8    = 5'h08;
  localparam logic [4:0] KEY_9    = 5'h09;
  localparam logic [4:0] KEY_A    = 5'h0A;
  localparam logic [4:0] KEY_B    = 5'h0B;
  localparam logic [4:0] KEY_C    = 5'h0C;
  localparam logic [4:0] KEY_D    = 5'h0D;
  localparam logic [4:0] KEY_E    = 5'h0E;
  localparam logic [4:0] KEY_F    = 5'h0F;

  localparam logic [4:0] ACT_UP_KEY    = KEY_2;
  localparam logic [4:0] ACT_DOWN_KEY  = KEY_8;
  localparam logic [4:0] ACT_LEFT_KEY  = KEY_4;
  localparam logic [4:0] ACT_RIGHT_KEY = KEY_6;
  localparam logic [4:0] ACT_BOMB_KEY  = KEY_5;

  typedef enum logic [1:0] {COL0, COL1, COL2, COL3} col_state_t;

  function automatic logic [4:0] key_lookup(input logic [1:0] col, input logic [1:0] row);
    logic [4:0] code;
    case ({col, row})
      4'h0: code = KEY_1;  4'h1: code = KEY_4;  4'h2: code = KEY_7;  4'h3: code = KEY_0;
      4'h4: code = KEY_2;  4'h5: code = KEY_5;  4'h6: code = KEY_8;  4'h7: code = KEY_F;
      4'h8: code = KEY_3;  4'h9: code = KEY_6;  4'hA: code = KEY_9;  4'hB: code = KEY_E;
      default: begin
        case (row)
          2'd0:    code = KEY_A;
          2'd1:    code = KEY_B;
          2'd2:    code = KEY_C;
          default: code = KEY_D;
        endcase
      end
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Accepts a new stable key only after DEBOUNCE_SWEEPS identical sweep candidates,
// strobing o_change in the cycle the stable value updates.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SWEEPS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] i_candidate,
  input  logic       i_sweep_end,
  output logic [4:0] o_stable,
  output logic       o_change
);

  localparam int CNT_W = $clog2(DEBOUNCE_SWEEPS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SWEEPS);

  logic [4:0]       r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_cnt_next = CNT_W'(1);
    if (i_candidate == r_prev)
      w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
  end

  // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev   <= KEY_NONE;
      r_cnt    <= '0;
      o_stable <= KEY_NONE;
      o_change <= 1'b0;
    end else begin
      o_change <= 1'b0;
      if (i_sweep_end) begin
        r_prev <= i_candidate;
        r_cnt  <= w_cnt_next;
        if (w_cnt_next == CNT_MAX && i_candidate != o_stable) begin
          o_stable <= i_candidate;
          o_change <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pmod_keypad_scanner.sv
// Column-scans the 4x4 Pmod keypad, debounces whole-sweep results and emits
// key events plus player-B action strobes.
module pmod_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 100000,
  parameter int DEBOUNCE_SWEEPS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] col_n,
  input  logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       act_up,
  output logic       act_down,
  output logic       act_left,
  output logic       act_right,
  output logic       act_bomb
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [3:0]       r_row_meta;
  logic [3:0]       r_row_sync;
  col_state_t       r_col;
  col_state_t       w_col_next;
  logic [DIV_W-1:0] r_div;
  logic [15:0]      r_sweep;
  logic             r_sweep_end;
  logic [4:0]       w_candidate;
  logic [4:0]       w_single;
  logic [4:0]       w_hits;
  logic [4:0]       w_stable;
  logic             w_change;

  assign w_col_next = col_state_t'(r_col + 2'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_meta  <= 4'hF;
      r_row_sync  <= 4'hF;
      r_col       <= COL0;
      r_div       <= '0;
      r_sweep     <= '0;
      r_sweep_end <= 1'b0;
      col_n       <= 4'b1110;
    end else begin
      r_row_meta  <= row_n;
      r_row_sync  <= r_row_meta;
      r_sweep_end <= 1'b0;
      if (r_div == DIV_LAST) begin
        r_div                       <= '0;
        r_sweep[{r_col, 2'b00} +: 4] <= ~r_row_sync;
        r_col                       <= w_col_next;
        col_n                       <= ~(4'b0001 << w_col_next);
        r_sweep_end                 <= (r_col == COL3);
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
    end
  end

  // Exactly one pressed bit names a key; none or several (ghosting) means no key.
  always_comb begin
    w_hits      = '0;
    w_single    = KEY_NONE;
    w_candidate = KEY_NONE;
    for (int i = 0; i < 16; i++) begin
      if (r_sweep[i]) begin
        w_hits   = w_hits + 5'd1;
        w_single = key_lookup(2'(i / 4), 2'(i % 4));
      end
    end
    if (w_hits == 5'd1)
      w_candidate = w_single;
  end

  keypad_debounce #(
    .DEBOUNCE_SWEEPS(DEBOUNCE_SWEEPS)
  ) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_candidate(w_candidate),
    .i_sweep_end(r_sweep_end),
    .o_stable   (w_stable),
    .o_change   (w_change)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      act_up    <= 1'b0;
      act_down  <= 1'b0;
      act_left  <= 1'b0;
      act_right <= 1'b0;
      act_bomb  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      act_up    <= 1'b0;
      act_down  <= 1'b0;
      act_left  <= 1'b0;
      act_right <= 1'b0;
      act_bomb  <= 1'b0;
      if (w_change) begin
        if (w_stable == KEY_NONE) begin
          key_held <= 1'b0;
        end else begin
          key_code  <= w_stable[3:0];
          key_valid <= 1'b1;
          key_held  <= 1'b1;
          act_up    <= (w_stable == ACT_UP_KEY);
          act_down  <= (w_stable == ACT_DOWN_KEY);
          act_left  <= (w_stable == ACT_LEFT_KEY);
          act_right <= (w_stable == ACT_RIGHT_KEY);
          act_bomb  <= (w_stable == ACT_BOMB_KEY);
        end
      end
    end
  end

endmodule
